// File: rtl/multdiv_pkg.sv
// Shared constants, FSM state encoding and helpers for the iterative multiplier/divider.
package multdiv_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned ITER  = 32;
   localparam int unsigned CNT_W = 6;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMult = 2'd1,
      StDiv  = 2'd2,
      StDone = 2'd3
   } state_e;

   // Magnitude of a two's-complement word; 0x80000000 maps to 2^31 read as unsigned.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: synchronous clear/enable, flags the last iteration (count == ITER-1).
module multdiv_counter
   import multdiv_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   logic [CNT_W-1:0] r_count;

   // Count iterations; a start (clear) restarts from zero.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_terminal = (r_count == CNT_W'(ITER - 1));

endmodule

// File: rtl/multdiv_iterative.sv
// Iterative signed 32-bit multiply (shift-add) and divide (restoring) unit.
// A start edge latches the raw operands, the next cycle converts them to magnitudes,
// then 32 iterations run; the result is registered on the edge that enters DONE.
module multdiv_iterative
   import multdiv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);

   state_e r_state;
   state_e w_state_nxt;

   logic                 r_prep;      // magnitude-conditioning cycle pending
   logic [WIDTH-1:0]     r_a;         // dividend magnitude, shifted into quotient
   logic [WIDTH-1:0]     r_b;         // multiplier (shifted right) or divisor
   logic [2*WIDTH-1:0]   r_mcand;     // multiplicand, shifted left each iteration
   logic [2*WIDTH-1:0]   r_acc;       // product magnitude accumulator
   logic [WIDTH-1:0]     r_rem;       // partial remainder
   logic                 r_neg;       // result sign
   logic                 r_div_zero;
   logic [WIDTH-1:0]     r_result;
   logic                 r_exc;

   logic                 w_start;
   logic                 w_busy;
   logic                 w_iter;
   logic                 w_terminal;
   logic [2*WIDTH-1:0]   w_acc_nxt;
   logic [WIDTH:0]       w_rem_shift;
   logic [WIDTH:0]       w_rem_diff;
   logic                 w_q_bit;
   logic [WIDTH-1:0]     w_rem_nxt;
   logic [WIDTH-1:0]     w_q_nxt;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quot;
   logic [WIDTH-1:0]     w_fin_result;
   logic                 w_fin_exc;

   assign w_start = ctrl_MULT | ctrl_DIV;
   assign w_busy  = (r_state == StMult) || (r_state == StDiv);
   assign w_iter  = w_busy && !r_prep;

   multdiv_counter u_counter (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_start),
      .i_enable   (w_iter),
      .o_terminal (w_terminal)
   );

   // One shift-add step and one restoring-division step.
   assign w_acc_nxt   = r_b[0] ? (r_acc + r_mcand) : r_acc;
   assign w_rem_shift = {r_rem, r_a[WIDTH-1]};
   assign w_rem_diff  = w_rem_shift - {1'b0, r_b};
   assign w_q_bit     = ~w_rem_diff[WIDTH];
   assign w_rem_nxt   = w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
   assign w_q_nxt     = {r_a[WIDTH-2:0], w_q_bit};

   // Sign fix-up and exception detection on the final iteration's values.
   assign w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
   assign w_quot = r_neg ? -w_q_nxt : w_q_nxt;

   // Select the completed result for the operation in flight.
   always_comb begin
      w_fin_result = '0;
      w_fin_exc    = 1'b0;
      if (r_state == StMult) begin
         w_fin_result = w_prod[WIDTH-1:0];
         w_fin_exc    = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
      end else if (r_div_zero) begin
         w_fin_result = '0;
         w_fin_exc    = 1'b1;
      end else begin
         w_fin_result = w_quot;
         // A positive quotient of 2^31 only arises from 0x80000000 / -1.
         w_fin_exc    = ~r_neg & w_q_nxt[WIDTH-1];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: a start pulse wins from any state, multiply over divide.
   always_comb begin
      w_state_nxt = r_state;
      if (ctrl_MULT) begin
         w_state_nxt = StMult;
      end else if (ctrl_DIV) begin
         w_state_nxt = StDiv;
      end else begin
         unique case (r_state)
            StIdle:         w_state_nxt = StIdle;
            StMult, StDiv:  w_state_nxt = (!r_prep && w_terminal) ? StDone : r_state;
            StDone:         w_state_nxt = StIdle;
            default:        w_state_nxt = StIdle;
         endcase
      end
   end

   // Datapath: latch on start, condition operands, iterate, capture result at completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prep     <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_mcand    <= '0;
         r_acc      <= '0;
         r_rem      <= '0;
         r_neg      <= 1'b0;
         r_div_zero <= 1'b0;
         r_result   <= '0;
         r_exc      <= 1'b0;
      end else if (w_start) begin
         r_a    <= data_operandA;
         r_b    <= data_operandB;
         r_prep <= 1'b1;
      end else if (w_busy) begin
         if (r_prep) begin
            r_prep     <= 1'b0;
            r_a        <= abs_val(r_a);
            r_b        <= abs_val(r_b);
            r_mcand    <= {{WIDTH{1'b0}}, abs_val(r_a)};
            r_neg      <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
            r_div_zero <= (r_b == '0);
            r_acc      <= '0;
            r_rem      <= '0;
         end else begin
            if (r_state == StMult) begin
               r_acc   <= w_acc_nxt;
               r_mcand <= r_mcand << 1;
               r_b     <= {1'b0, r_b[WIDTH-1:1]};
            end else begin
               r_a   <= w_q_nxt;
               r_rem <= w_rem_nxt;
            end
            if (w_terminal) begin
               r_result <= w_fin_result;
               r_exc    <= w_fin_exc;
            end
         end
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exc;
   assign data_resultRDY = (r_state == StDone);

endmodule

// File: tb/tb_multdiv_iterative.sv
// Self-checking bench for multdiv_iterative: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_multdiv_iterative;

   localparam int LAT = 33;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int n_cmp = 0;
   int n_bad = 0;

   multdiv_iterative dut (
      .clk            (clk),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {exception, result} from signed 64-bit arithmetic.
   function automatic logic [32:0] ref_model(input logic is_mul, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint lim = 64'sh7FFFFFFF;
      longint r;
      logic   e;
      if (is_mul) begin
         r = sa * sb;
         e = (r > lim) || (r < -lim - 1);
      end else if (b == 32'd0) begin
         r = 0;
         e = 1'b1;
      end else begin
         r = sa / sb;
         e = (r > lim);
      end
      return {e, r[31:0]};
   endfunction

   // Apply a one-cycle start; returns #1 after the start edge with operands scrambled.
   task automatic launch(input logic mul, input logic div, input logic [31:0] a,
                         input logic [31:0] b);
      @(negedge clk);
      ctrl_MULT     = mul;
      ctrl_DIV      = div;
      data_operandA = a;
      data_operandB = b;
      @(posedge clk);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   // Watch n edges; report the edge index of the first ready pulse and the pulse count.
   task automatic watch(input int n, output int first, output int pulses,
                        output logic [31:0] r, output logic e);
      first  = 0;
      pulses = 0;
      r      = '0;
      e      = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         if (data_resultRDY === 1'b1) begin
            pulses++;
            if (first == 0) begin
               first = k;
               r     = data_result;
               e     = data_exception;
            end
         end
      end
   endtask

   task automatic run_op(input string tag, input logic mul, input logic div,
                         input logic [31:0] a, input logic [31:0] b);
      logic [32:0] exp;
      int          first, pulses;
      logic [31:0] r;
      logic        e;
      exp = ref_model(mul, a, b);
      launch(mul, div, a, b);
      watch(LAT + 3, first, pulses, r, e);
      check({tag, " latency"}, 64'(first), 64'(LAT));
      check({tag, " pulses"}, 64'(pulses), 64'd1);
      check({tag, " result"}, 64'(r), 64'(exp[31:0]));
      check({tag, " exception"}, 64'(e), 64'(exp[32]));
   endtask

   initial begin
      int          first, pulses, pre;
      logic [31:0] r, a, b;
      logic        e;

      reset = 1'b1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset result", 64'(data_result), 64'd0);
      check("reset exception", 64'(data_exception), 64'd0);
      check("reset ready", 64'(data_resultRDY), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      watch(5, first, pulses, r, e);
      check("idle no ready", 64'(pulses), 64'd0);

      // Directed cases.
      run_op("mul 7*-3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
      check("mul 7*-3 literal", 64'(data_result), 64'hFFFFFFEB);
      run_op("mul ovf", 1'b1, 1'b0, 32'h00010000, 32'h00010000);
      run_op("div -7/2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
      check("div -7/2 literal", 64'(data_result), 64'hFFFFFFFD);
      run_op("div by 0", 1'b0, 1'b1, 32'd100, 32'd0);
      run_op("div min/-1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
      run_op("div min/1", 1'b0, 1'b1, 32'h80000000, 32'd1);
      run_op("mul min*1", 1'b1, 1'b0, 32'h80000000, 32'd1);
      run_op("mul min*-1", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
      run_op("both starts", 1'b1, 1'b1, 32'd9, 32'd3);

      // Restart: divide abandoned by a multiply ten cycles later.
      launch(1'b0, 1'b1, 32'd20, 32'd3);
      pre = 0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         if (data_resultRDY === 1'b1) pre++;
      end
      launch(1'b1, 1'b0, 32'd5, 32'd6);
      if (data_resultRDY === 1'b1) pre++;
      watch(LAT + 6, first, pulses, r, e);
      check("restart pulses", 64'(pre + pulses), 64'd1);
      check("restart latency", 64'(first), 64'(LAT));
      check("restart result", 64'(r), 64'd30);
      check("restart exception", 64'(e), 64'd0);

      // Reset at cycle 15 of a multiply.
      launch(1'b1, 1'b0, 32'h00012345, 32'h00006789);
      pre = 0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         #1;
         if (data_resultRDY === 1'b1) pre++;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort result", 64'(data_result), 64'd0);
      check("abort exception", 64'(data_exception), 64'd0);
      check("abort ready", 64'(data_resultRDY), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      watch(LAT + 6, first, pulses, r, e);
      check("abort no ready", 64'(pre + pulses), 64'd0);
      run_op("mul 3*4", 1'b1, 1'b0, 32'd3, 32'd4);

      // Reset has priority over a simultaneous start.
      @(negedge clk);
      reset = 1'b1;
      ctrl_MULT = 1'b1;
      data_operandA = 32'd5;
      data_operandB = 32'd5;
      @(posedge clk);
      #1;
      check("rst+start result", 64'(data_result), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      ctrl_MULT = 1'b0;
      watch(LAT + 6, first, pulses, r, e);
      check("rst+start no ready", 64'(pulses), 64'd0);

      // Randomized operations.
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 2 == 0) begin
            a = 32'($signed(16'($urandom)));
            b = 32'($signed(16'($urandom)));
         end
         run_op($sformatf("rnd mul %0d", i), 1'b1, 1'b0, a, b);
      end
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 2 == 0) begin
            b = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) b = -b;
         end
         run_op($sformatf("rnd div %0d", i), 1'b0, 1'b1, a, b);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
